// File: rtl/match_event_monitor_if.sv
// Handshake bundle between the match-event monitor and its driver.
// The driver supplies the control inputs; the monitor returns the counters, window pulse and alarm.
interface match_event_monitor_if #(
  parameter int CNT_W  = 8,
  parameter int WINDOW = 16
);
  logic                             enable;
  logic                             match_pulse;
  logic                             clear;
  logic                             alarm_ack;
  logic [CNT_W-1:0]                 total_count;
  logic [$clog2(WINDOW+1)-1:0]      window_count;
  logic                             window_done;
  logic                             alarm;

  modport master (
    output enable, match_pulse, clear, alarm_ack,
    input  total_count, window_count, window_done, alarm
  );

  modport slave (
    input  enable, match_pulse, clear, alarm_ack,
    output total_count, window_count, window_done, alarm
  );
endinterface

// File: rtl/match_event_monitor.sv
// Counts pattern-detector matches over fixed windows, keeps a saturating lifetime
// total and raises a sticky alarm when a window reaches THRESH matches.
module match_event_monitor #(
  parameter int CNT_W  = 8,
  parameter int WINDOW = 16,
  parameter int THRESH = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  match_event_monitor_if.slave    bus
);
  localparam int WC_W  = $clog2(WINDOW + 1);
  localparam int TMR_W = $clog2(WINDOW);

  typedef enum logic [1:0] {IDLE, COUNT, ALARM} state_t;

  state_t             state;
  logic [TMR_W-1:0]   timer;
  logic [WC_W-1:0]    wcount;
  logic [CNT_W-1:0]   total;
  logic               done;
  logic               alarm_r;

  logic [WC_W-1:0]    wc_next;
  logic               count_pulse;
  logic               last_cycle;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  always_comb begin
    wc_next     = wcount + WC_W'(bus.match_pulse);
    count_pulse = bus.enable && bus.match_pulse && (state != IDLE);
    last_cycle  = (timer == TMR_W'(WINDOW - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      timer   <= '0;
      wcount  <= '0;
      total   <= '0;
      done    <= 1'b0;
      alarm_r <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.clear) begin
        // Clear wins over everything, including a coincident match.
        total   <= '0;
        wcount  <= '0;
        timer   <= '0;
        alarm_r <= 1'b0;
        state   <= bus.enable ? COUNT : IDLE;
      end else begin
        if (count_pulse) total <= sat_inc(total);
        case (state)
          IDLE: begin
            timer  <= '0;
            wcount <= '0;
            if (bus.enable) state <= COUNT;
          end
          COUNT: begin
            if (!bus.enable) begin
              state  <= IDLE;
              timer  <= '0;
              wcount <= '0;
            end else if (last_cycle) begin
              done <= 1'b1;
              if (wc_next >= WC_W'(THRESH)) begin
                // Freeze the offending window's count for the status reader.
                alarm_r <= 1'b1;
                wcount  <= wc_next;
                state   <= ALARM;
              end else begin
                timer  <= '0;
                wcount <= '0;
              end
            end else begin
              timer  <= timer + 1'b1;
              wcount <= wc_next;
            end
          end
          ALARM: begin
            if (bus.alarm_ack) begin
              alarm_r <= 1'b0;
              timer   <= '0;
              wcount  <= '0;
              state   <= bus.enable ? COUNT : IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.total_count  = total;
  assign bus.window_count = wcount;
  assign bus.window_done  = done;
  assign bus.alarm        = alarm_r;
endmodule
